// File: rtl/serializador_perfil.sv
// serializador_perfil: sends a captured 3-bit interface profile as a serial frame.
// Frame layout: start(0), perfil[0], perfil[1], perfil[2], even parity, stop(1).
// Each bit is held CICLOS_BIT clocks. All outputs are registered.
module serializador_perfil #(
  parameter int CICLOS_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] perfil,
  input  logic       enviar,
  output logic       tx,
  output logic       ocupado,
  output logic       concluido,
  output logic       descartado
);

  typedef enum logic [2:0] {
    OCIOSO,
    INICIO,
    DADOS,
    PARIDADE,
    PARADA
  } estado_t;

  localparam logic [7:0] ULTIMO = 8'(CICLOS_BIT - 1);

  estado_t    estado;
  logic [7:0] cnt;   // cycles spent on the current bit
  logic [1:0] idx;   // data bit index while in DADOS
  logic [2:0] cap;   // profile frozen at request time; tx never looks at perfil
  logic       fim;   // last cycle of the current bit

  assign fim = (cnt == ULTIMO);

  // Frame sequencer: state, bit timing and every registered output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado     <= OCIOSO;
      cnt        <= '0;
      idx        <= '0;
      cap        <= '0;
      tx         <= 1'b1;
      ocupado    <= 1'b0;
      concluido  <= 1'b0;
      descartado <= 1'b0;
    end else begin
      // pulses last a single cycle unless re-armed below
      concluido  <= 1'b0;
      descartado <= 1'b0;
      case (estado)
        OCIOSO: begin
          cnt     <= '0;
          idx     <= '0;
          tx      <= 1'b1;
          ocupado <= 1'b0;
          if (enviar) begin
            if (perfil != 3'b000) begin
              cap     <= perfil;
              estado  <= INICIO;
              tx      <= 1'b0;
              ocupado <= 1'b1;
            end else begin
              descartado <= 1'b1;
            end
          end
        end
        INICIO: begin
          if (fim) begin
            cnt    <= '0;
            idx    <= '0;
            estado <= DADOS;
            tx     <= cap[0];
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DADOS: begin
          if (fim) begin
            cnt <= '0;
            if (idx == 2'd2) begin
              idx    <= '0;
              estado <= PARIDADE;
              tx     <= ^cap;
            end else begin
              idx <= idx + 2'd1;
              tx  <= cap[idx + 2'd1];
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        PARIDADE: begin
          if (fim) begin
            cnt    <= '0;
            estado <= PARADA;
            tx     <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        PARADA: begin
          if (fim) begin
            cnt       <= '0;
            estado    <= OCIOSO;
            tx        <= 1'b1;
            ocupado   <= 1'b0;
            concluido <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          estado  <= OCIOSO;
          cnt     <= '0;
          idx     <= '0;
          tx      <= 1'b1;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule
